fragment_hazard_guard: RTL and testbench

- Sits directly upstream of the per-fragment pipeline, between the rasterizer/texture output and the framebuffer read/modify/write stage.
- The per-fragment stage reads color/depth/stencil at issue and writes back 5 cycles later, with no backpressure. A second fragment to the same index issued inside that window would read stale data.
- This block holds any fragment whose framebuffer index matches a fragment still in flight, and issues it only after the older write has landed.
- It also provides a drain/flush handshake so that a later framebuffer commit sees only completed writes.

---
 rtl/fragment_hazard_guard_pkg.sv | 16 +
 rtl/fragment_hazard_guard_if.sv | 38 +++
 rtl/fragment_hazard_guard_window.sv | 48 ++++
 rtl/fragment_hazard_guard.sv | 148 ++++++++++++++
 tb/tb_fragment_hazard_guard.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fragment_hazard_guard_pkg.sv
// Shared constants and types for the fragment hazard guard.
package fragment_hazard_guard_pkg;

  // Cycles between a fragment's issue and its framebuffer write landing.
  localparam int PIPE_WRITE_LATENCY = 5;

  // An issued index keeps blocking until its write has landed, plus one cycle.
  localparam int DEFAULT_HAZARD_WINDOW = PIPE_WRITE_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fragment_hazard_guard_if.sv
// Fragment stream bundle: upstream (s_) accept side and downstream (m_) issue side.
interface fragment_hazard_guard_if #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int SCREEN_POS_WIDTH        = 16,
  parameter int SUB_PIXEL_WIDTH         = 8
);
  localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

  logic                               s_valid;
  logic                               s_ready;
  logic [PIXEL_WIDTH-1:0]             s_fragmentColor;
  logic [31:0]                        s_depth;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_index;
  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosX;
  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosY;

  logic                               m_valid;
  logic [PIXEL_WIDTH-1:0]             m_fragmentColor;
  logic [31:0]                        m_depth;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index;
  logic [SCREEN_POS_WIDTH-1:0]        m_screenPosX;
  logic [SCREEN_POS_WIDTH-1:0]        m_screenPosY;

  // Rasterizer feeding the guard and per-fragment pipeline consuming it.
  modport master (
    output s_valid, s_fragmentColor, s_depth, s_index, s_screenPosX, s_screenPosY,
    input  s_ready,
    input  m_valid, m_fragmentColor, m_depth, m_index, m_screenPosX, m_screenPosY
  );

  // The guard itself.
  modport slave (
    input  s_valid, s_fragmentColor, s_depth, s_index, s_screenPosX, s_screenPosY,
    output s_ready,
    output m_valid, m_fragmentColor, m_depth, m_index, m_screenPosX, m_screenPosY
  );

endinterface

// File: rtl/fragment_hazard_guard_window.sv
// Sliding record of recently issued framebuffer indices with a parallel
// compare against the index currently waiting to issue.
module fragment_hazard_guard_window
  import fragment_hazard_guard_pkg::*;
#(
  parameter int INDEX_WIDTH   = 14,
  parameter int HAZARD_WINDOW = DEFAULT_HAZARD_WINDOW  // legal range 1..16
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   load_valid_i,  // a fragment issues this cycle
  input  logic [INDEX_WIDTH-1:0] index_i,       // pending index: loaded and compared
  output logic                   hit_o,
  output logic                   any_valid_o
);

  logic [HAZARD_WINDOW-1:0] slot_valid_q;
  logic [INDEX_WIDTH-1:0]   slot_index_q [HAZARD_WINDOW];
  logic [HAZARD_WINDOW-1:0] slot_hit;

  // Valid bits age one slot per cycle; slot 0 records this cycle's issue.
  always_ff @(posedge aclk) begin
    if (reset) begin
      slot_valid_q <= '0;
    end else begin
      slot_valid_q[0] <= load_valid_i;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        slot_valid_q[i] <= slot_valid_q[i-1];
      end
    end
  end

  // Index payload ages alongside; it is meaningless when its valid bit is low.
  always_ff @(posedge aclk) begin
    slot_index_q[0] <= index_i;
    for (int i = 1; i < HAZARD_WINDOW; i++) begin
      slot_index_q[i] <= slot_index_q[i-1];
    end
  end

  for (genvar gi = 0; gi < HAZARD_WINDOW; gi++) begin : g_cmp
    assign slot_hit[gi] = slot_valid_q[gi] && (slot_index_q[gi] == index_i);
  end

  assign hit_o       = |slot_hit;
  assign any_valid_o = |slot_valid_q;

endmodule

// File: rtl/fragment_hazard_guard.sv
// Holds back a fragment whose framebuffer index is still being written by the
// per-fragment pipeline, issues strictly in order, and offers a drain handshake.
module fragment_hazard_guard
  import fragment_hazard_guard_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int SCREEN_POS_WIDTH        = 16,
  parameter int SUB_PIXEL_WIDTH         = 8,
  parameter int HAZARD_WINDOW           = DEFAULT_HAZARD_WINDOW,
  parameter int STALL_CNT_WIDTH         = 32
) (
  input  logic                       aclk,
  input  logic                       reset,
  fragment_hazard_guard_if.slave     frag,
  input  logic                       flushReq,
  output logic                       flushDone,
  output logic                       busy,
  output logic [STALL_CNT_WIDTH-1:0] stallCycles
);

  localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

  state_e state_q, state_d;

  logic                               pend_valid_q;
  logic [PIXEL_WIDTH-1:0]             pend_color_q;
  logic [31:0]                        pend_depth_q;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] pend_index_q;
  logic [SCREEN_POS_WIDTH-1:0]        pend_pos_x_q;
  logic [SCREEN_POS_WIDTH-1:0]        pend_pos_y_q;

  logic                               m_valid_q;
  logic [PIXEL_WIDTH-1:0]             m_color_q;
  logic [31:0]                        m_depth_q;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index_q;
  logic [SCREEN_POS_WIDTH-1:0]        m_pos_x_q;
  logic [SCREEN_POS_WIDTH-1:0]        m_pos_y_q;

  logic [STALL_CNT_WIDTH-1:0] stall_q;

  logic hit;
  logic any_valid;
  logic issue;
  logic s_ready;
  logic accept;

  // Pending slot frees the same cycle it issues, so a new fragment can refill it.
  assign issue   = pend_valid_q && !hit;
  assign s_ready = (state_q == ST_RUN) && (!pend_valid_q || issue);
  assign accept  = frag.s_valid && s_ready;

  assign busy        = pend_valid_q || any_valid;
  assign flushDone   = (state_q == ST_DONE);
  assign stallCycles = stall_q;

  assign frag.s_ready         = s_ready;
  assign frag.m_valid         = m_valid_q;
  assign frag.m_fragmentColor = m_color_q;
  assign frag.m_depth         = m_depth_q;
  assign frag.m_index         = m_index_q;
  assign frag.m_screenPosX    = m_pos_x_q;
  assign frag.m_screenPosY    = m_pos_y_q;

  fragment_hazard_guard_window #(
    .INDEX_WIDTH   (FRAMEBUFFER_INDEX_WIDTH),
    .HAZARD_WINDOW (HAZARD_WINDOW)
  ) u_window (
    .aclk         (aclk),
    .reset        (reset),
    .load_valid_i (issue),
    .index_i      (pend_index_q),
    .hit_o        (hit),
    .any_valid_o  (any_valid)
  );

  // Pending occupancy: set on accept, cleared on issue unless refilled.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
    end else if (issue) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Pending payload captured at the handshake.
  always_ff @(posedge aclk) begin
    if (accept) begin
      pend_color_q <= frag.s_fragmentColor;
      pend_depth_q <= frag.s_depth;
      pend_index_q <= frag.s_index;
      pend_pos_x_q <= frag.s_screenPosX;
      pend_pos_y_q <= frag.s_screenPosY;
    end
  end

  // Issue register: pulse valid on issue, keep the last fragment's data otherwise.
  always_ff @(posedge aclk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_color_q <= '0;
      m_depth_q <= '0;
      m_index_q <= '0;
      m_pos_x_q <= '0;
      m_pos_y_q <= '0;
    end else begin
      m_valid_q <= issue;
      if (issue) begin
        m_color_q <= pend_color_q;
        m_depth_q <= pend_depth_q;
        m_index_q <= pend_index_q;
        m_pos_x_q <= pend_pos_x_q;
        m_pos_y_q <= pend_pos_y_q;
      end
    end
  end

  // Count cycles a waiting fragment is held by a hazard (free-running wrap).
  always_ff @(posedge aclk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (pend_valid_q && hit) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  // Flush FSM state register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush FSM next state: drain until nothing is pending or in flight, then pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flushReq) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy)    state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_fragment_hazard_guard.sv
// Randomized and directed bench for fragment_hazard_guard, checked against a
// timestamp-based reference model of the hazard rules.
module tb_fragment_hazard_guard;
  import fragment_hazard_guard_pkg::*;

  localparam int IW  = 14;
  localparam int PW  = 16;
  localparam int SW  = 8;
  localparam int CW  = 32;
  localparam int HW  = 6;
  localparam int PXW = 4 * SW;

  typedef struct packed {
    logic [PXW-1:0] color;
    logic [31:0]    depth;
    logic [IW-1:0]  idx;
    logic [PW-1:0]  x;
    logic [PW-1:0]  y;
  } frag_t;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          flushReq = 1'b0;
  logic          flushDone;
  logic          busy;
  logic [CW-1:0] stallCycles;

  fragment_hazard_guard_if #(
    .FRAMEBUFFER_INDEX_WIDTH (IW),
    .SCREEN_POS_WIDTH        (PW),
    .SUB_PIXEL_WIDTH         (SW)
  ) fif ();

  fragment_hazard_guard #(
    .FRAMEBUFFER_INDEX_WIDTH (IW),
    .SCREEN_POS_WIDTH        (PW),
    .SUB_PIXEL_WIDTH         (SW),
    .HAZARD_WINDOW           (HW),
    .STALL_CNT_WIDTH         (CW)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .frag        (fif),
    .flushReq    (flushReq),
    .flushDone   (flushDone),
    .busy        (busy),
    .stallCycles (stallCycles)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: one pending slot, output register, and the edge number at
  // which each index last issued. An index blocks for HW cycles after its issue.
  int         cyc = 0;
  bit         md_pend_v = 1'b0;
  frag_t      md_pend = '0;
  bit         md_out_v = 1'b0;
  frag_t      md_out = '0;
  int         md_state = 0;  // 0 run, 1 drain, 2 done
  logic [CW-1:0] md_stall = '0;
  int         md_last_issue [int];
  int         md_last_any = -1000;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic frag_t rand_frag();
    frag_t f;
    f.color = PXW'($urandom());
    f.depth = $urandom();
    f.x     = PW'($urandom());
    f.y     = PW'($urandom());
    case ($urandom_range(0, 7))
      0:       f.idx = 14'h0000;
      1:       f.idx = 14'h0001;
      2:       f.idx = 14'h0007;
      3:       f.idx = 14'h0009;
      4:       f.idx = 14'h2007;
      5:       f.idx = 14'h2001;
      6:       f.idx = 14'h3fff;
      default: f.idx = 14'h1000;
    endcase
    return f;
  endfunction

  function automatic frag_t mk(input int idx);
    frag_t f;
    f = rand_frag();
    f.idx = IW'(idx);
    return f;
  endfunction

  task automatic model_reset();
    md_pend_v   = 1'b0;
    md_out_v    = 1'b0;
    md_out      = '0;
    md_state    = 0;
    md_stall    = '0;
    md_last_any = -1000;
    md_last_issue.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic run_cycle(input bit v, input frag_t f, input bit fr, input bit rst, output bit acc);
    bit blocked;
    bit win_busy;
    bit exp_ready;
    bit issue;
    @(negedge aclk);
    reset               = rst;
    flushReq            = fr;
    fif.s_valid         = v;
    fif.s_fragmentColor = f.color;
    fif.s_depth         = f.depth;
    fif.s_index         = f.idx;
    fif.s_screenPosX    = f.x;
    fif.s_screenPosY    = f.y;
    #1;
    blocked = 1'b0;
    if (md_pend_v && md_last_issue.exists(int'(md_pend.idx))) begin
      blocked = (cyc - md_last_issue[int'(md_pend.idx)]) < HW;
    end
    win_busy  = (cyc - md_last_any) < HW;
    exp_ready = (md_state == 0) && (!md_pend_v || !blocked);
    if (chk_en) begin
      check("s_ready",     128'(fif.s_ready), 128'(exp_ready));
      check("busy",        128'(busy),        128'(md_pend_v || win_busy));
      check("flushDone",   128'(flushDone),   128'(md_state == 2));
      check("stallCycles", 128'(stallCycles), 128'(md_stall));
      check("m_valid",     128'(fif.m_valid), 128'(md_out_v));
      check("m_fragment",
            128'({fif.m_fragmentColor, fif.m_depth, fif.m_index, fif.m_screenPosX, fif.m_screenPosY}),
            128'(md_out));
      if (md_out_v) $display("[TB] cycle %0d issue idx=%0h depth=%0h", cyc, md_out.idx, md_out.depth);
    end
    acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      issue = md_pend_v && !blocked;
      acc   = v && exp_ready;
      if (blocked) md_stall = md_stall + 1'b1;
      if (md_state == 0) begin
        if (fr) md_state = 1;
      end else if (md_state == 1) begin
        if (!(md_pend_v || win_busy)) md_state = 2;
      end else begin
        md_state = 0;
      end
      md_out_v = issue;
      if (issue) begin
        md_out = md_pend;
        md_last_issue[int'(md_pend.idx)] = cyc + 1;
        md_last_any = cyc + 1;
      end
      if (acc) begin
        md_pend_v = 1'b1;
        md_pend   = f;
      end else if (issue) begin
        md_pend_v = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) run_cycle(1'b0, rand_frag(), 1'b0, 1'b0, acc);
  endtask

  // Hold a fragment on the input until the model says it was taken.
  task automatic send(input frag_t f);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      run_cycle(1'b1, f, 1'b0, 1'b0, acc);
      n++;
    end
    check("accept_bound", 128'(acc), 128'(1));
  endtask

  initial begin
    bit acc;
    fif.s_valid         = 1'b0;
    fif.s_fragmentColor = '0;
    fif.s_depth         = '0;
    fif.s_index         = '0;
    fif.s_screenPosX    = '0;
    fif.s_screenPosY    = '0;

    // Reset: first cycle unknown, second cycle checks the reset state.
    run_cycle(1'b0, rand_frag(), 1'b0, 1'b1, acc);
    chk_en = 1'b1;
    run_cycle(1'b0, rand_frag(), 1'b0, 1'b1, acc);

    // Distinct indices back to back.
    for (int i = 0; i < 4; i++) send(mk(i));
    idle(8);

    // Same index twice, then a non-conflicting index stuck behind it.
    send(mk(7));
    send(mk(7));
    idle(12);
    send(mk(7));
    send(mk(7));
    send(mk(3));
    idle(12);

    // Full-width compare: low bits match, high bits differ.
    send(mk(14'h0007));
    send(mk(14'h2007));
    idle(10);

    // Flush requested while a fragment is in flight.
    send(mk(9));
    run_cycle(1'b0, rand_frag(), 1'b1, 1'b0, acc);
    idle(12);

    // Reset with a blocked pending fragment and a full window.
    for (int i = 1; i <= 5; i++) send(mk(i));
    send(mk(7));
    send(mk(7));
    run_cycle(1'b0, rand_frag(), 1'b0, 1'b1, acc);
    idle(2);
    send(mk(9));
    idle(8);

    // Flush while idle, with fragments offered during the drain.
    run_cycle(1'b0, rand_frag(), 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, mk(5), 1'b0, 1'b0, acc);
    idle(10);

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 800; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), rand_frag(),
                ($urandom_range(0, 40) == 0), ($urandom_range(0, 200) == 0), acc);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
